tx_gearbox_66b64b: RTL and testbench

- Transmit gearbox directly downstream of the 64b/66b scrambler-coder stage.
- Accepts one 66-bit block per handshake: 2-bit sync header plus 64-bit scrambled payload.
- Emits a continuous stream of 64-bit words for the SerDes/PMA interface; 32 input blocks produce 33 output words.
- Uses AXI-Stream-style valid/ready on both sides.

---
 rtl/pcs_64b66b_pkg.sv | 26 ++
 rtl/tx_gearbox_66b64b.sv | 111 +++++++++++
 tb/tb_tx_gearbox_66b64b.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcs_64b66b_pkg.sv
// Shared 64b/66b PCS definitions: block layout, sync header codes and widths.
package pcs_64b66b_pkg;

    localparam int unsigned BLOCK_W  = 66;
    localparam int unsigned PMA_W    = 64;
    localparam int unsigned GB_BUF_W = 130;
    localparam int unsigned GB_CNT_W = 8;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef struct packed {
        logic [1:0]  sync;
        logic [63:0] payload;
    } block_t;

    function automatic logic is_legal_sync(input logic [1:0] sync);
        return (sync == SYNC_DATA) || (sync == SYNC_CTRL);
    endfunction

    // Line order is sync[0], sync[1], payload[0..63]; bit 0 goes out first.
    function automatic logic [BLOCK_W-1:0] serialize_block(input block_t blk);
        return {blk.payload, blk.sync[1], blk.sync[0]};
    endfunction

endpackage

// File: rtl/tx_gearbox_66b64b.sv
// 66b -> 64b transmit gearbox: 130-bit shift buffer between a block source and the PMA.
// Optional header checker enabled with `define GEARBOX_HDR_CHECK_EN.
module tx_gearbox_66b64b
    import pcs_64b66b_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [66:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [PMA_W-1:0]     m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready
`ifdef GEARBOX_HDR_CHECK_EN
    ,
    output logic                 hdr_err,
    output logic [ERR_CNT_W-1:0] hdr_err_cnt
`endif
);

    logic [GB_BUF_W-1:0] buf_q;
    logic [GB_BUF_W-1:0] buf_d;
    logic [GB_CNT_W-1:0] cnt_q;
    logic [GB_CNT_W-1:0] cnt_d;

    block_t              blk;
    logic [BLOCK_W-1:0]  blk_ser;
    logic                push;
    logic                pop;
    logic [GB_BUF_W-1:0] shifted;
    logic [GB_BUF_W-1:0] keep_mask;
    logic [GB_CNT_W-1:0] base_cnt;
    logic [5:0]          wr_base;
    logic                unused_tdata_msb;

    assign blk              = block_t'(s_axis_tdata[BLOCK_W-1:0]);
    assign blk_ser          = serialize_block(blk);
    assign unused_tdata_msb = s_axis_tdata[66];

    assign m_axis_tvalid = (cnt_q >= GB_CNT_W'(PMA_W));
    assign m_axis_tdata  = buf_q[PMA_W-1:0];
    // Ready at high fill only when a word leaves this cycle, so the buffer never exceeds 129 bits.
    assign s_axis_tready = (cnt_q <= GB_CNT_W'(PMA_W - 1))
                         | (m_axis_tready & (cnt_q <= GB_CNT_W'(2 * PMA_W - 1)));

    assign push = s_axis_tvalid & s_axis_tready;
    assign pop  = m_axis_tvalid & m_axis_tready;

    // Pop shift first, then splice the new block right above the surviving bits.
    always_comb begin
        shifted   = buf_q;
        base_cnt  = cnt_q;
        if (pop) begin
            shifted  = buf_q >> PMA_W;
            base_cnt = cnt_q - GB_CNT_W'(PMA_W);
        end
        wr_base   = 6'(base_cnt);
        keep_mask = ~({GB_BUF_W{1'b1}} << wr_base);
        buf_d     = shifted;
        cnt_d     = base_cnt;
        if (push) begin
            buf_d = (shifted & keep_mask) | (GB_BUF_W'(blk_ser) << wr_base);
            cnt_d = base_cnt + GB_CNT_W'(BLOCK_W);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef GEARBOX_HDR_CHECK_EN
    logic                 hdr_err_q;
    logic                 hdr_err_d;
    logic [ERR_CNT_W-1:0] hdr_err_cnt_q;
    logic [ERR_CNT_W-1:0] hdr_err_cnt_d;

    // Flag accepted blocks with 00/11 headers; count saturates at all-ones.
    always_comb begin
        hdr_err_d     = push & ~is_legal_sync(blk.sync);
        hdr_err_cnt_d = hdr_err_cnt_q;
        if (hdr_err_d && (hdr_err_cnt_q != '1)) begin
            hdr_err_cnt_d = hdr_err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_err_q     <= 1'b0;
            hdr_err_cnt_q <= '0;
        end else begin
            hdr_err_q     <= hdr_err_d;
            hdr_err_cnt_q <= hdr_err_cnt_d;
        end
    end

    assign hdr_err     = hdr_err_q;
    assign hdr_err_cnt = hdr_err_cnt_q;
`else
    logic [ERR_CNT_W-1:0] unused_err_cnt_w;
    assign unused_err_cnt_w = '0;
`endif

endmodule

// File: tb/tb_tx_gearbox_66b64b.sv
// Bench for tx_gearbox_66b64b: hand vectors plus a bit-queue serialization model.
module tb_tx_gearbox_66b64b;

`ifdef GEARBOX_HDR_CHECK_EN
    localparam int unsigned TB_ERR_W = 2;
`else
    localparam int unsigned TB_ERR_W = 16;
`endif

    logic        clk;
    logic        reset_n;
    logic [66:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
`ifdef GEARBOX_HDR_CHECK_EN
    logic                hdr_err;
    logic [TB_ERR_W-1:0] hdr_err_cnt;
`endif

    tx_gearbox_66b64b #(.ERR_CNT_W(TB_ERR_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef GEARBOX_HDR_CHECK_EN
        ,
        .hdr_err       (hdr_err),
        .hdr_err_cnt   (hdr_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference model: the ordered line bits not yet handed to the PMA.
    bit q[$];
    logic        last_push, last_pop, last_dut_tv, last_dut_tr;
    logic [63:0] last_dut_td;
    logic        hold_valid;
    logic [63:0] hold_data;
    logic        exp_hdr;
    int          illegal_n;
    int          pulses;

    typedef struct {
        logic        v;
        logic [66:0] d;
        logic        mr;
        logic        exp_tv;
        logic        exp_tr;
        logic        chk_data;
        logic [63:0] exp_data;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [66:0] mk(input logic [1:0] hdr, input logic [63:0] p);
        logic [66:0] d;
        d = {1'($urandom_range(0, 1)), hdr, p};
        return d;
    endfunction

    function automatic logic [66:0] rnd_blk();
        logic [1:0] h;
        h = $urandom_range(0, 1) ? 2'b01 : 2'b10;
        return mk(h, {$urandom, $urandom});
    endfunction

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        q.delete();
        hold_valid = 1'b0;
        exp_hdr    = 1'b0;
        illegal_n  = 0;
        pulses     = 0;
    endtask

    // One clock: drive, compare against the model, then advance the model on the edge.
    task automatic step(input logic v, input logic [66:0] d, input logic mr);
        int          nb;
        logic        etv, etr;
        logic [63:0] ew;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = mr;
        #1;
        nb  = q.size();
        etv = (nb >= 64);
        etr = (nb <= 63) || (mr && nb <= 127);
        last_dut_tv = m_axis_tvalid;
        last_dut_tr = s_axis_tready;
        last_dut_td = m_axis_tdata;
        check("m_tvalid", 64'(m_axis_tvalid), 64'(etv));
        check("s_tready", 64'(s_axis_tready), 64'(etr));
        if (etv) begin
            for (int i = 0; i < 64; i++) ew[i] = q[i];
            check("m_tdata", m_axis_tdata, ew);
        end
        if (hold_valid) check("tdata_stable", m_axis_tdata, hold_data);
`ifdef GEARBOX_HDR_CHECK_EN
        check("hdr_err", 64'(hdr_err), 64'(exp_hdr));
        if (hdr_err === 1'b1) pulses++;
`endif
        hold_valid = etv && !mr;
        hold_data  = m_axis_tdata;
        last_push  = v && etr;
        last_pop   = etv && mr;
        @(posedge clk);
        if (last_pop) repeat (64) void'(q.pop_front());
        if (last_push) begin
            q.push_back(d[64]);
            q.push_back(d[65]);
            for (int i = 0; i < 64; i++) q.push_back(d[i]);
        end
        exp_hdr = last_push && !(d[65:64] == 2'b01 || d[65:64] == 2'b10);
        if (exp_hdr) illegal_n++;
        @(negedge clk);
    endtask

    task automatic goto_cnt(input int target);
        int n;
        n = 0;
        while (q.size() != target && n < 400) begin
            step(1'b1, rnd_blk(), 1'b1);
            n++;
        end
        check("reach_cnt", 64'(q.size()), 64'(target));
    endtask

    vec_t tbl[4];
    int   pushed, cyc, words, bubbles, last_stall, n;
    logic seen_word;
    logic [63:0] p;
    logic [1:0]  hl[5];

    initial begin
        tests = 0;
        fails = 0;
        do_reset();

        // Single block, hand-computed expectations.
        tbl[0] = '{1'b1, {3'b001, 64'h0123_4567_89AB_CDEF}, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
        tbl[1] = '{1'b0, 67'h0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h048D_159E_26AF_37BD};
        tbl[2] = '{1'b0, 67'h0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
        tbl[3] = '{1'b0, 67'h0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = tbl[i].v;
            s_axis_tdata  = tbl[i].d;
            m_axis_tready = tbl[i].mr;
            #1;
            check($sformatf("tbl%0d_tvalid", i), 64'(m_axis_tvalid), 64'(tbl[i].exp_tv));
            check($sformatf("tbl%0d_tready", i), 64'(s_axis_tready), 64'(tbl[i].exp_tr));
            if (tbl[i].chk_data) check($sformatf("tbl%0d_tdata", i), m_axis_tdata, tbl[i].exp_data);
            @(posedge clk);
            @(negedge clk);
        end

        // Continuous stream, both sides always ready.
        do_reset();
        pushed = 0; cyc = 0; words = 0; bubbles = 0; last_stall = -1; seen_word = 1'b0;
        while (pushed < 330 && cyc < 2000) begin
            step(1'b1, mk((pushed % 7 == 0) ? 2'b10 : 2'b01, 64'(pushed)), 1'b1);
            if (last_push) pushed++;
            else begin
                if (last_stall < 0) check("first_stall_cycle", 64'(cyc), 64'd32);
                else check("stall_gap", 64'(cyc - last_stall), 64'd33);
                last_stall = cyc;
            end
            if (seen_word && !last_dut_tv) bubbles++;
            if (last_pop) begin
                words++;
                seen_word = 1'b1;
            end
            cyc++;
        end
        check("stream_pushed", 64'(pushed), 64'd330);
        n = 0;
        while (q.size() >= 64 && n < 100) begin
            step(1'b0, 67'h0, 1'b1);
            if (last_pop) words++;
            n++;
        end
        check("stream_words", 64'(words), 64'((330 * 66) / 64));
        check("stream_residue", 64'(q.size()), 64'((330 * 66) % 64));
        check("stream_bubbles", 64'(bubbles), 64'd0);

        // Random backpressure and random source gaps.
        do_reset();
        pushed = 0; n = 0;
        while (pushed < 1000 && n < 20000) begin
            step(($urandom_range(0, 3) != 0), rnd_blk(), 1'($urandom_range(0, 1)));
            if (last_push) pushed++;
            n++;
        end
        check("bp_pushed", 64'(pushed), 64'd1000);
        n = 0;
        while (q.size() >= 64 && n < 200) begin
            step(1'b0, 67'h0, 1'($urandom_range(0, 1)));
            n++;
        end
        check("bp_drained", 64'(q.size() < 64), 64'd1);

        // Boundary at fill 128: stalled input, pop frees space only on the following cycle.
        do_reset();
        goto_cnt(128);
        step(1'b1, rnd_blk(), 1'b0);
        check("bnd128_tready_bp", 64'(last_dut_tr), 64'd0);
        step(1'b1, rnd_blk(), 1'b0);
        check("bnd128_tvalid_bp", 64'(last_dut_tv), 64'd1);
        step(1'b1, rnd_blk(), 1'b1);
        check("bnd128_tready_pop", 64'(last_dut_tr), 64'd0);
        step(1'b1, rnd_blk(), 1'b1);
        check("bnd64_push", 64'(last_dut_tr), 64'd1);
        check("bnd64_cnt", 64'(q.size()), 64'd66);
        // Mid-range fill: raising m_axis_tready makes the input ready in the same cycle.
        goto_cnt(100);
        step(1'b1, rnd_blk(), 1'b0);
        check("bnd100_tready_bp", 64'(last_dut_tr), 64'd0);
        step(1'b1, rnd_blk(), 1'b1);
        check("bnd100_tready_pop", 64'(last_dut_tr), 64'd1);
        check("bnd100_cnt", 64'(q.size()), 64'd102);

        // Reset in the middle of a stream.
        do_reset();
        goto_cnt(70);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        reset_n       = 1'b0;
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        hold_valid = 1'b0;
        exp_hdr = 1'b0;
        illegal_n = 0;
        pulses = 0;
        p = 64'hFEDC_BA98_7654_3210;
        step(1'b1, mk(2'b10, p), 1'b1);
        step(1'b0, 67'h0, 1'b1);
        check("rst_first_word", last_dut_td, {p[61:0], 1'b1, 1'b0});
        step(1'b0, 67'h0, 1'b1);
        check("rst_leftover", 64'(last_dut_tv), 64'd0);

`ifdef GEARBOX_HDR_CHECK_EN
        do_reset();
        hl = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 5; i++) step(1'b1, mk(hl[i], {$urandom, $urandom}), 1'b1);
        step(1'b0, 67'h0, 1'b1);
        check("hdr_pulses", 64'(pulses), 64'd3);
        check("hdr_cnt", 64'(hdr_err_cnt), 64'd3);
        step(1'b1, mk(2'b11, {$urandom, $urandom}), 1'b1);
        step(1'b0, 67'h0, 1'b1);
        check("hdr_pulses_sat", 64'(pulses), 64'd4);
        check("hdr_cnt_sat", 64'(hdr_err_cnt),
              64'((illegal_n > (2 ** TB_ERR_W - 1)) ? (2 ** TB_ERR_W - 1) : illegal_n));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
